// File: rtl/axis_packetizer_if.sv
// AXI-Stream bundle shared by the packetizer ports; sidebands drop out under USE_LIGHT_STREAM.
// m drives the stream, s consumes it.
interface axis_if #(
  parameter int DATA_WIDTH = 32
`ifndef USE_LIGHT_STREAM
  ,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
`endif
);
  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
`ifndef USE_LIGHT_STREAM
  logic [ID_WIDTH-1:0]   TID;
  logic [DEST_WIDTH-1:0] TDEST;
  logic [USER_WIDTH-1:0] TUSER;

  modport m (output TVALID, TDATA, TLAST, TID, TDEST, TUSER, input TREADY);
  modport s (input TVALID, TDATA, TLAST, TID, TDEST, TUSER, output TREADY);
`else
  modport m (output TVALID, TDATA, TLAST, input TREADY);
  modport s (input TVALID, TDATA, TLAST, output TREADY);
`endif
endinterface

// File: rtl/axis_packetizer.sv
// Prepends a routing header flit to req_length payload flits; header is valid the cycle after
// the request is taken. Header stalls on out.TREADY; body passes backpressure straight to in.
module axis_packetizer #(
  parameter int DATA_WIDTH = 32,
`ifndef USE_LIGHT_STREAM
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4,
`endif
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int MAXIMUM_PACKAGES_NUMBER = 5,
  localparam int XW = $clog2(MAX_ROUTERS_X),
  localparam int YW = $clog2(MAX_ROUTERS_Y),
  localparam int PW = $clog2(MAXIMUM_PACKAGES_NUMBER - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] req_target_x,
  input  logic [YW-1:0] req_target_y,
  input  logic [PW-1:0] req_length,
  axis_if.s             in,
  axis_if.m             out,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   tx_q;
  logic [YW-1:0]   ty_q;
  logic [PW-1:0]   len_q;
  logic [PW-1:0]   rem_q;
  logic [DATA_WIDTH-1:0] header;

  assign header = DATA_WIDTH'({len_q, ty_q, tx_q});

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    busy       = (state_q != IDLE);
    in.TREADY  = 1'b0;
    out.TVALID = 1'b0;
    out.TDATA  = '0;
    out.TLAST  = 1'b0;
`ifndef USE_LIGHT_STREAM
    out.TID    = {ID_WIDTH{1'b0}};
    out.TDEST  = {DEST_WIDTH{1'b0}};
    out.TUSER  = {USER_WIDTH{1'b0}};
`endif
    case (state_q)
      IDLE: begin
        // rst_n gates req_ready so nothing is offered while reset is held
        req_ready = rst_n;
        if (req_valid) state_d = HEADER;
      end
      HEADER: begin
        out.TVALID = 1'b1;
        out.TDATA  = header;
        out.TLAST  = (len_q == '0);
        if (out.TREADY) state_d = (len_q == '0) ? IDLE : BODY;
      end
      BODY: begin
        out.TVALID = in.TVALID;
        in.TREADY  = out.TREADY;
        out.TDATA  = in.TDATA;
`ifndef USE_LIGHT_STREAM
        out.TID    = in.TID;
        out.TDEST  = in.TDEST;
        out.TUSER  = in.TUSER;
`endif
        out.TLAST  = (rem_q == PW'(1));
        if (in.TVALID && out.TREADY && rem_q == PW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          tx_q  <= req_target_x;
          ty_q  <= req_target_y;
          len_q <= req_length;
        end
        HEADER: if (out.TREADY) rem_q <= len_q;
        // the final flit leaves rem_q at 1 rather than wrapping
        BODY: if (in.TVALID && out.TREADY && rem_q != PW'(1)) rem_q <= rem_q - PW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: table of single packets plus stall/gap/reset/back-to-back sequences.
module tb_axis_packetizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_target_x;
  logic [1:0] req_target_y;
  logic [1:0] req_length;
  logic       busy;

  axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) s_if ();
  axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) m_if ();

  axis_packetizer #(
    .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4),
    .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .MAXIMUM_PACKAGES_NUMBER(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_target_x(req_target_x), .req_target_y(req_target_y), .req_length(req_length),
    .in(s_if), .out(m_if), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;

  always @(posedge clk) if (m_if.TVALID && m_if.TREADY) xfer_cnt <= xfer_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  x;
    logic [1:0]  y;
    logic [1:0]  len;
    logic [31:0] base;
    logic [31:0] hdr;
  } vec_t;

  // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the following IDLE cycle.
  task automatic run_packet(input vec_t v);
    int busy_cycles = 0;
    req_valid = 1'b1; req_target_x = v.x; req_target_y = v.y; req_length = v.len;
    m_if.TREADY = 1'b1; s_if.TVALID = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);
    check("idle_out_valid", m_if.TVALID, 0);
    @(negedge clk);
    req_valid = 1'b1; req_target_x = ~v.x; req_target_y = ~v.y; req_length = ~v.len;
    s_if.TVALID = 1'b1; s_if.TDATA = 32'hDEAD_BEEF; s_if.TID = 4'h9; s_if.TDEST = 4'h6; s_if.TUSER = 4'h3;
    #1;
    req_valid = 1'b0;
    check("hdr_valid", m_if.TVALID, 1);
    check("hdr_data", m_if.TDATA, v.hdr);
    check("hdr_last", m_if.TLAST, (v.len == 0));
    check("hdr_in_ready", s_if.TREADY, 0);
    check("hdr_sideband", {m_if.TID, m_if.TDEST, m_if.TUSER}, 0);
    if (busy) busy_cycles++;
    for (int i = 0; i < int'(v.len); i++) begin
      @(negedge clk);
      s_if.TDATA = v.base + 32'(i);
      s_if.TID = 4'(i + 1); s_if.TDEST = 4'(i + 5); s_if.TUSER = 4'(i + 9);
      s_if.TLAST = (i == 0);
      #1;
      check("body_data", m_if.TDATA, v.base + 32'(i));
      check("body_last", m_if.TLAST, (i == int'(v.len) - 1));
      check("body_in_ready", s_if.TREADY, 1);
      check("body_sideband", {m_if.TID, m_if.TDEST, m_if.TUSER}, {4'(i + 1), 4'(i + 5), 4'(i + 9)});
      if (busy) busy_cycles++;
    end
    @(negedge clk);
    s_if.TVALID = 1'b0; s_if.TLAST = 1'b0;
    #1;
    check("end_busy", busy, 0);
    check("end_req_ready", req_ready, 1);
    check("end_in_ready", s_if.TREADY, 0);
    check("busy_cycles", busy_cycles, int'(v.len) + 1);
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  initial begin
    vec_t vecs [5];
    int   start;
    int   k;
    logic [4:0] pat;

    vecs[0] = '{x: 2'd2, y: 2'd3, len: 2'd3, base: 32'hA0, hdr: 32'h3E};
    vecs[1] = '{x: 2'd1, y: 2'd0, len: 2'd0, base: 32'h00, hdr: 32'h01};
    vecs[2] = '{x: 2'd3, y: 2'd3, len: 2'd1, base: 32'h55, hdr: 32'h1F};
    vecs[3] = '{x: 2'd0, y: 2'd1, len: 2'd2, base: 32'h10, hdr: 32'h24};
    vecs[4] = '{x: 2'd3, y: 2'd0, len: 2'd2, base: 32'hF0, hdr: 32'h23};

    rst_n = 1'b0; req_valid = 1'b1; req_target_x = '0; req_target_y = '0; req_length = '0;
    s_if.TVALID = 1'b1; s_if.TDATA = '0; s_if.TLAST = 1'b0; s_if.TID = '0; s_if.TDEST = '0; s_if.TUSER = '0;
    m_if.TREADY = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", m_if.TVALID, 0);
    check("rst_in_ready", s_if.TREADY, 0);
    @(negedge clk);
    req_valid = 1'b0; s_if.TVALID = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);

    for (int i = 0; i < 5; i++) run_packet(vecs[i]);

    // Stalls in header and first body flit
    start = xfer_cnt;
    req_valid = 1'b1; req_target_x = 2'd1; req_target_y = 2'd1; req_length = 2'd2;
    m_if.TREADY = 1'b0; s_if.TVALID = 1'b1; s_if.TDATA = 32'hB0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_hdr_data", m_if.TDATA, 32'h25);
      check("stall_hdr_in_ready", s_if.TREADY, 0);
      @(negedge clk);
    end
    m_if.TREADY = 1'b1;
    #1;
    check("stall_hdr_release", m_if.TDATA, 32'h25);
    @(negedge clk);
    m_if.TREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_body_data", m_if.TDATA, 32'hB0);
      check("stall_body_in_ready", s_if.TREADY, 0);
      check("stall_body_last", m_if.TLAST, 0);
      @(negedge clk);
    end
    m_if.TREADY = 1'b1;
    #1;
    check("stall_body0", m_if.TDATA, 32'hB0);
    @(negedge clk);
    s_if.TDATA = 32'hB1;
    #1;
    check("stall_body1", m_if.TDATA, 32'hB1);
    check("stall_body1_last", m_if.TLAST, 1);
    @(negedge clk);
    s_if.TVALID = 1'b0;
    #1;
    check("stall_end_busy", busy, 0);
    check("stall_flits", xfer_cnt - start, 3);

    // Gapped input valid
    start = xfer_cnt;
    pat = 5'b10101;
    k = 0;
    req_valid = 1'b1; req_target_x = 2'd0; req_target_y = 2'd0; req_length = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("gap_hdr", m_if.TDATA, 32'h30);
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      s_if.TVALID = pat[p]; s_if.TDATA = 32'hC0 + 32'(k);
      #1;
      check("gap_out_valid", m_if.TVALID, pat[p]);
      if (pat[p]) begin
        check("gap_data", m_if.TDATA, 32'hC0 + 32'(k));
        check("gap_last", m_if.TLAST, (k == 2));
        k++;
      end
    end
    @(negedge clk);
    s_if.TVALID = 1'b0;
    #1;
    check("gap_end_busy", busy, 0);
    check("gap_flits", xfer_cnt - start, 4);

    // Reset mid-packet
    req_valid = 1'b1; req_target_x = 2'd2; req_target_y = 2'd1; req_length = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("mid_rst_hdr", m_if.TDATA, 32'h36);
    @(negedge clk);
    s_if.TVALID = 1'b1; s_if.TDATA = 32'hD0;
    #1;
    check("mid_rst_body0", m_if.TDATA, 32'hD0);
    @(negedge clk);
    s_if.TDATA = 32'hD1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", m_if.TVALID, 0);
    check("mid_rst_in_ready", s_if.TREADY, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_ready", req_ready, 1);
    check("mid_rst_release_valid", m_if.TVALID, 0);
    s_if.TVALID = 1'b0;
    run_packet('{x: 2'd3, y: 2'd3, len: 2'd1, base: 32'hE0, hdr: 32'h1F});

    // Back-to-back requests with req_valid held
    req_valid = 1'b1; req_target_x = 2'd1; req_target_y = 2'd2; req_length = 2'd1;
    m_if.TREADY = 1'b1; s_if.TVALID = 1'b1; s_if.TDATA = 32'hF0;
    #1;
    check("b2b_c0_ready", req_ready, 1);
    @(negedge clk);
    #1;
    check("b2b_c1_ready", req_ready, 0);
    check("b2b_hdr1", m_if.TDATA, 32'h19);
    @(negedge clk);
    #1;
    check("b2b_c2_ready", req_ready, 0);
    check("b2b_tlast1", m_if.TLAST, 1);
    check("b2b_data1", m_if.TDATA, 32'hF0);
    @(negedge clk);
    #1;
    check("b2b_c3_ready", req_ready, 1);
    req_target_x = 2'd2;
    @(negedge clk);
    req_valid = 1'b0; s_if.TDATA = 32'hF1;
    #1;
    check("b2b_hdr2", m_if.TDATA, 32'h1A);
    @(negedge clk);
    #1;
    check("b2b_data2", m_if.TDATA, 32'hF1);
    check("b2b_tlast2", m_if.TLAST, 1);
    @(negedge clk);
    s_if.TVALID = 1'b0;
    #1;
    check("b2b_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
